// File: rtl/pong_pkg.sv
// Shared state encodings, key codes and BCD helper for the pong game controller.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } pong_state_e;

    // Index p holds the key for player p.
    localparam logic [3:0][7:0] KEY_UP    = {8'h38, 8'h69, 8'h70, 8'h77};
    localparam logic [3:0][7:0] KEY_DOWN  = {8'h32, 8'h6B, 8'h6C, 8'h73};
    localparam logic [7:0]      KEY_SPACE = 8'h20;
    localparam int              MAX_DIGITS = 8;

    function automatic int unsigned bcd_to_bin(input logic [4*MAX_DIGITS-1:0] bcd,
                                               input int digits);
        int unsigned acc;
        acc = 0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < digits) acc = acc * 10 + 32'(bcd[4*i +: 4]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/pong_bcd_counter.sv
// Multi-digit BCD score counter: synchronous clear, increment with wrap from all-nines to zero.
module pong_bcd_counter #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [DIGITS*4-1:0] value_o
);

    logic [DIGITS*4-1:0] value_q, value_d;
    logic                carry;

    always_comb begin
        value_d = value_q;
        carry   = inc_i;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value_q[4*i +: 4] == 4'd9) begin
                    value_d[4*i +: 4] = 4'd0;
                end else begin
                    value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (clr_i) value_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value_o = value_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game control: UART key decode with paddle hold, game-flow FSM, scores and ball count.
// Define PONG_WIN_SCORE_EN to end the game as soon as a player reaches WIN_SCORE.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int PLAYERS      = 2,
    parameter int DIGITS       = 2,
    parameter int BALLS        = 7,
    parameter int SERVE_FRAMES = 120,
    parameter int OVER_FRAMES  = 180,
    parameter int HOLD_FRAMES  = 4,
    parameter int WIN_SCORE    = 11
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_tick,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    input  logic [PLAYERS-1:0]            pts,
    output logic [PLAYERS-1:0]            key_up,
    output logic [PLAYERS-1:0]            key_down,
    output logic                          gra_still,
    output logic [1:0]                    state,
    output logic [$clog2(BALLS+1)-1:0]    balls_left,
    output logic [PLAYERS*DIGITS*4-1:0]   scores,
    output logic [1:0]                    winner
);

    localparam int          BW        = $clog2(BALLS + 1);
    localparam int          TMAX      = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
    localparam int          TW        = $clog2(TMAX + 1);
    localparam int          HW        = $clog2(HOLD_FRAMES + 1);
    localparam int unsigned SCORE_MOD = 10 ** DIGITS;
`ifdef PONG_WIN_SCORE_EN
    localparam int unsigned WIN_TARGET = WIN_SCORE;
`else
    // A wrapped score never equals SCORE_MOD, so the early-win check is inert.
    localparam int unsigned WIN_TARGET = SCORE_MOD;
`endif

    pong_state_e         state_q;
    logic [TW-1:0]       timer_q;
    logic [BW-1:0]       balls_q;
    logic                gra_still_q;
    logic [1:0]          winner_q;

    logic [PLAYERS-1:0]  up_hit, dn_hit, inc;
    logic [DIGITS*4-1:0] score_bcd [PLAYERS];
    int unsigned         next_bin  [PLAYERS];
    int unsigned         best_val;
    logic [1:0]          sel, best;
    logic                hit, win_hit, start, clr;

    assign start = rx_valid && ((rx_data == KEY_SPACE) || (|up_hit) || (|dn_hit));
    assign clr   = (state_q == ST_NEWGAME) || ((state_q == ST_OVER) && (timer_q == '0));

    // Only the lowest-index scorer counts, and only during play.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int p = PLAYERS - 1; p >= 0; p--) begin
            if (pts[p]) begin
                hit = 1'b1;
                sel = 2'(p);
            end
        end
        if (state_q != ST_PLAY) hit = 1'b0;
    end

    // Post-increment scores drive both the early-win check and the leader at game end.
    always_comb begin
        win_hit  = 1'b0;
        best     = '0;
        best_val = 0;
        for (int p = 0; p < PLAYERS; p++) begin
            next_bin[p] = bcd_to_bin(32'(score_bcd[p]), DIGITS);
            if (inc[p]) next_bin[p] = (next_bin[p] + 1 == SCORE_MOD) ? 0 : next_bin[p] + 1;
            if (inc[p] && (next_bin[p] == WIN_TARGET)) win_hit = 1'b1;
            if ((p == 0) || (next_bin[p] > best_val)) begin
                best_val = next_bin[p];
                best     = 2'(p);
            end
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [HW-1:0] hold_q;
        logic          up_q, dn_q;

        assign up_hit[p] = rx_valid && (rx_data == KEY_UP[p]);
        assign dn_hit[p] = rx_valid && (rx_data == KEY_DOWN[p]);
        assign inc[p]    = hit && (sel == 2'(p));

        // A fresh key byte reloads the hold even on a frame_tick cycle.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hold_q <= '0;
                up_q   <= 1'b0;
                dn_q   <= 1'b0;
            end else if (up_hit[p] || dn_hit[p]) begin
                hold_q <= HW'(HOLD_FRAMES);
                up_q   <= up_hit[p];
                dn_q   <= dn_hit[p];
            end else if (frame_tick && (hold_q != '0)) begin
                hold_q <= hold_q - HW'(1);
                if (hold_q == HW'(1)) begin
                    up_q <= 1'b0;
                    dn_q <= 1'b0;
                end
            end
        end

        assign key_up[p]   = up_q;
        assign key_down[p] = dn_q;

        pong_bcd_counter #(.DIGITS(DIGITS)) u_score (
            .clk     (clk),
            .reset   (reset),
            .clr_i   (clr),
            .inc_i   (inc[p]),
            .value_o (score_bcd[p])
        );

        assign scores[p*DIGITS*4 +: DIGITS*4] = score_bcd[p];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_NEWGAME;
            timer_q     <= '0;
            balls_q     <= '0;
            gra_still_q <= 1'b1;
            winner_q    <= '0;
        end else begin
            case (state_q)
                ST_NEWGAME: begin
                    balls_q <= BW'(BALLS);
                    if (start) begin
                        state_q     <= ST_PLAY;
                        gra_still_q <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (hit) begin
                        balls_q     <= balls_q - BW'(1);
                        gra_still_q <= 1'b1;
                        if (win_hit || (balls_q == BW'(1))) begin
                            state_q  <= ST_OVER;
                            timer_q  <= TW'(OVER_FRAMES);
                            winner_q <= win_hit ? sel : best;
                        end else begin
                            state_q <= ST_NEWBALL;
                            timer_q <= TW'(SERVE_FRAMES);
                        end
                    end
                end
                ST_NEWBALL: begin
                    // Start keys arriving while the serve timer runs are simply dropped.
                    if ((timer_q == '0) && start) begin
                        state_q     <= ST_PLAY;
                        gra_still_q <= 1'b0;
                    end else if (frame_tick && (timer_q != '0)) begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                ST_OVER: begin
                    if (timer_q == '0) begin
                        state_q <= ST_NEWGAME;
                        balls_q <= BW'(BALLS);
                    end else if (frame_tick) begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: state_q <= ST_NEWGAME;
            endcase
        end
    end

    assign state      = state_q;
    assign gra_still  = gra_still_q;
    assign balls_left = balls_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: directed game flow plus randomized play against a game-rules model.
module tb_pong_game_ctrl;

    localparam int PLAYERS = 2;
    localparam int DIGITS  = 2;
    localparam int BALLS   = 7;
    localparam int SERVE   = 120;
    localparam int OVERF   = 180;
    localparam int HOLD    = 4;
`ifdef PONG_WIN_SCORE_EN
    localparam int WIN    = 3;
    localparam bit WIN_EN = 1'b1;
    localparam int N_PTS  = 3;
`else
    localparam int WIN    = 11;
    localparam bit WIN_EN = 1'b0;
    localparam int N_PTS  = 5;
`endif
    localparam int BW = $clog2(BALLS + 1);

    // ---------------- clock / reset / DUT ----------------
    logic                        clk = 1'b0;
    logic                        reset;
    logic                        frame_tick;
    logic                        rx_valid;
    logic [7:0]                  rx_data;
    logic [PLAYERS-1:0]          pts;
    logic [PLAYERS-1:0]          key_up, key_down;
    logic                        gra_still;
    logic [1:0]                  state;
    logic [BW-1:0]               balls_left;
    logic [PLAYERS*DIGITS*4-1:0] scores;
    logic [1:0]                  winner;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .PLAYERS(PLAYERS), .DIGITS(DIGITS), .BALLS(BALLS), .SERVE_FRAMES(SERVE),
        .OVER_FRAMES(OVERF), .HOLD_FRAMES(HOLD), .WIN_SCORE(WIN)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .rx_valid(rx_valid),
        .rx_data(rx_data), .pts(pts), .key_up(key_up), .key_down(key_down),
        .gra_still(gra_still), .state(state), .balls_left(balls_left),
        .scores(scores), .winner(winner)
    );

    // ---------------- reference model (game rules) ----------------
    int       n_assert = 0;
    int       n_fail   = 0;
    int       m_mode, m_timer, m_balls, m_winner;
    int       m_score [PLAYERS];
    int       m_hold  [PLAYERS];
    bit       m_up    [PLAYERS];
    bit [7:0] up_k [4] = '{8'h77, 8'h70, 8'h69, 8'h38};
    bit [7:0] dn_k [4] = '{8'h73, 8'h6C, 8'h6B, 8'h32};

    task automatic model_reset();
        m_mode = 0; m_timer = 0; m_balls = 0; m_winner = 0;
        for (int p = 0; p < PLAYERS; p++) begin
            m_score[p] = 0; m_hold[p] = 0; m_up[p] = 1'b0;
        end
    endtask

    function automatic int leader();
        int b = 0;
        for (int p = 1; p < PLAYERS; p++) if (m_score[p] > m_score[b]) b = p;
        return b;
    endfunction

    task automatic model_edge(input bit ft, input bit rv, input bit [7:0] d,
                              input logic [PLAYERS-1:0] pt);
        bit start;
        int lo;
        start = rv && (d == 8'h20);
        for (int p = 0; p < PLAYERS; p++) begin
            if (rv && d == up_k[p]) begin
                m_hold[p] = HOLD; m_up[p] = 1'b1; start = 1'b1;
            end else if (rv && d == dn_k[p]) begin
                m_hold[p] = HOLD; m_up[p] = 1'b0; start = 1'b1;
            end else if (ft && m_hold[p] > 0) begin
                m_hold[p]--;
            end
        end
        case (m_mode)
            0: begin
                for (int p = 0; p < PLAYERS; p++) m_score[p] = 0;
                m_balls = BALLS;
                if (start) m_mode = 1;
            end
            1: if (pt != '0) begin
                lo = 0;
                while (!pt[lo]) lo++;
                m_score[lo] = (m_score[lo] + 1) % (10 ** DIGITS);
                m_balls--;
                if (WIN_EN && m_score[lo] == WIN) begin
                    m_mode = 3; m_timer = OVERF; m_winner = lo;
                end else if (m_balls == 0) begin
                    m_mode = 3; m_timer = OVERF; m_winner = leader();
                end else begin
                    m_mode = 2; m_timer = SERVE;
                end
            end
            2: begin
                if (m_timer == 0 && start) m_mode = 1;
                else if (ft && m_timer > 0) m_timer--;
            end
            default: begin
                if (m_timer == 0) begin
                    m_mode = 0; m_balls = BALLS;
                    for (int p = 0; p < PLAYERS; p++) m_score[p] = 0;
                end else if (ft) begin
                    m_timer--;
                end
            end
        endcase
    endtask

    function automatic logic [31:0] exp_scores();
        logic [31:0] v = '0;
        int s;
        for (int p = 0; p < PLAYERS; p++) begin
            s = m_score[p];
            for (int d = 0; d < DIGITS; d++) begin
                v[(p*DIGITS + d)*4 +: 4] = 4'(s % 10);
                s = s / 10;
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_keys(input bit up);
        logic [31:0] v = '0;
        for (int p = 0; p < PLAYERS; p++) v[p] = (m_hold[p] > 0) && (m_up[p] == up);
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("state",     32'(state),      32'(m_mode));
        check("balls",     32'(balls_left), 32'(m_balls));
        check("scores",    32'(scores),     exp_scores());
        check("key_up",    32'(key_up),     exp_keys(1'b1));
        check("key_down",  32'(key_down),   exp_keys(1'b0));
        check("gra_still", 32'(gra_still),  32'(m_mode != 1));
        if (m_mode == 3) check("winner", 32'(winner), 32'(m_winner));
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit ft, input bit rv, input bit [7:0] d,
                        input logic [PLAYERS-1:0] pt);
        frame_tick = ft; rx_valid = rv; rx_data = d; pts = pt;
        @(posedge clk);
        model_edge(ft, rv, d, pt);
        #1;
        frame_tick = 1'b0; rx_valid = 1'b0; pts = '0;
        check_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},  32'(state),      32'd0);
        check({tag, "_balls"},  32'(balls_left), 32'd0);
        check({tag, "_scores"}, 32'(scores),     32'd0);
        check({tag, "_up"},     32'(key_up),     32'd0);
        check({tag, "_down"},   32'(key_down),   32'd0);
        check({tag, "_still"},  32'(gra_still),  32'd1);
        check({tag, "_winner"}, 32'(winner),     32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; frame_tick = 1'b0; rx_valid = 1'b0; rx_data = '0; pts = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // New game and start
        step(0, 0, 8'h00, 2'b01);
        check("newgame_pts_ignored", 32'(scores), 32'd0);
        check("newgame_balls", 32'(balls_left), 32'd7);
        step(0, 1, 8'h20, 2'b00);
        check("start_state", 32'(state), 32'd1);
        check("start_balls", 32'(balls_left), 32'd7);
        check("start_still", 32'(gra_still), 32'd0);

        // First point, then serve timer
        step(0, 0, 8'h00, 2'b01);
        check("pt_state", 32'(state), 32'd2);
        check("pt_score", 32'(scores), 32'h0001);
        check("pt_balls", 32'(balls_left), 32'd6);
        repeat (SERVE - 1) step(1, 0, 8'h00, 2'b00);
        step(0, 1, 8'h77, 2'b00);
        check("early_key", 32'(state), 32'd2);
        step(1, 0, 8'h00, 2'b00);
        step(0, 1, 8'h77, 2'b00);
        check("late_key", 32'(state), 32'd1);

        // Simultaneous scorers: lowest index only
        step(0, 0, 8'h00, 2'b11);
        check("dual_score", 32'(scores), 32'h0002);
        check("dual_balls", 32'(balls_left), 32'd5);

        // Key hold timing
        step(0, 1, 8'h73, 2'b00);
        check("hold_down", 32'(key_down), 32'b01);
        for (int i = 1; i <= HOLD; i++) begin
            step(1, 0, 8'h00, 2'b00);
            check("hold_tick", 32'(key_down[0]), (i < HOLD) ? 32'd1 : 32'd0);
        end
        step(0, 1, 8'h73, 2'b00);
        step(1, 0, 8'h00, 2'b00);
        step(0, 1, 8'h77, 2'b00);
        check("swap_down", 32'(key_down[0]), 32'd0);
        check("swap_up", 32'(key_up[0]), 32'd1);
        step(1, 1, 8'h6C, 2'b00);
        check("reload_down1", 32'(key_down), 32'b10);
        repeat (HOLD - 1) step(1, 0, 8'h00, 2'b00);
        check("reload_wins", 32'(key_down), 32'b10);

        // Player 1 takes the remaining points
        for (int i = 0; i < N_PTS; i++) begin
            repeat (SERVE) step(1, 0, 8'h00, 2'b00);
            step(0, 1, 8'h20, 2'b00);
            step(0, 0, 8'h00, 2'b10);
        end
        check("over_state", 32'(state), 32'd3);
        check("over_winner", 32'(winner), 32'd1);
        check("over_balls", 32'(balls_left), 32'(5 - N_PTS));
        check("over_scores", 32'(scores), {16'h0, 8'(N_PTS), 8'h02});
        repeat (OVERF) step(1, 0, 8'h00, 2'b00);
        check("over_hold", 32'(state), 32'd3);
        step(0, 0, 8'h00, 2'b00);
        check("back_state", 32'(state), 32'd0);
        check("back_scores", 32'(scores), 32'd0);
        check("back_balls", 32'(balls_left), 32'd7);

        // Randomized play with one asynchronous reset mid-run
        for (int c = 0; c < 8000; c++) begin
            bit                 ft, rv;
            bit [7:0]           d;
            logic [PLAYERS-1:0] pt;
            int                 k;
            ft = ($urandom_range(0, 1) == 1);
            rv = ($urandom_range(0, 7) == 0);
            k  = $urandom_range(0, 10);
            if (k < 4)       d = up_k[k];
            else if (k < 8)  d = dn_k[k-4];
            else if (k == 8) d = 8'h20;
            else             d = 8'($urandom_range(0, 255));
            pt = '0;
            if ($urandom_range(0, 15) == 0) pt = PLAYERS'($urandom_range(1, (1 << PLAYERS) - 1));
            step(ft, rv, d, pt);
            if (c == 5000) begin
                #2 reset = 1'b1;
                #1;
                model_reset();
                check_reset_values("async_reset");
                @(posedge clk);
                #1 reset = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Parametrised game-control FSMD for the pong design: decodes UART key bytes into per-player paddle commands, sequences the newgame/play/newball/over flow with frame-based timers, and keeps per-player BCD scores and the remaining-ball count. Sits between the UART receiver and `pong_graph`/`pong_text`, replacing the hard-wired two-player control logic. Generalised to 1–4 players with configurable ball count and timers, a reachable game-over state, and paddle key-hold stretching.

## Interface
- PLAYERS, 2: number of players, 1..4
- DIGITS, 2: BCD digits per score
- BALLS, 7: balls per game, ≥1
- SERVE_FRAMES, 120: newball wait, frames (2 s at 60 Hz)
- OVER_FRAMES, 180: game-over display time, frames
- HOLD_FRAMES, 4: frames a paddle command is held after its key byte
- WIN_SCORE, 11: winning score (used only with PONG_WIN_SCORE_EN)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame (x==0 && y==0)
- rx_valid  in  1  one-cycle pulse, rx_data holds a new byte
- rx_data  in  8  received ASCII byte
- pts  in  PLAYERS  one-cycle pulse, bit i = player i scored
- key_up  out  PLAYERS  paddle-up hold, per player
- key_down  out  PLAYERS  paddle-down hold, per player
- gra_still  out  1  1 = freeze graphics
- state  out  2  00 newgame, 01 play, 10 newball, 11 over
- balls_left  out  $clog2(BALLS+1)  balls remaining
- scores  out  PLAYERS*DIGITS*4  BCD scores, player 0 in LSBs
- winner  out  2  winning player index, valid in over

## Operation
- Key map (player 0..3): up 'w','p','i','8' (8'h77,8'h70,8'h69,8'h38); down 's','l','k','2' (8'h73,8'h6C,8'h6B,8'h32). Start key = any mapped key of an active player or space 8'h20. Unmapped bytes ignored.
- Key hold: a mapped byte loads that player's counter with HOLD_FRAMES and sets the matching direction, clearing the opposite one. Counter decrements on frame_tick; output drops when it reaches 0. A new byte reloads the counter.
- NEWGAME: gra_still=1, scores cleared, balls_left=BALLS. Start key → PLAY.
- PLAY: gra_still=0. Scoring pulse: only the lowest set pts bit counts; that score increments (wrap at 10^DIGITS−1 → 0) and balls_left decrements. Then balls_left==0 → OVER with timer=OVER_FRAMES, otherwise → NEWBALL with timer=SERVE_FRAMES.
- NEWBALL: gra_still=1. Leave for PLAY only after the timer reaches 0 and a start key arrives. Start keys received earlier are discarded.
- OVER: gra_still=1. Timer reaches 0 → NEWGAME.
- pts is ignored outside PLAY. rx bytes always update key holds in every state.
- Without PONG_WIN_SCORE_EN, winner = highest score; ties go to the lowest index.

## Timing
- Reset values: state=00, balls_left=0, scores=0, key_up=key_down=0, gra_still=1, winner=0, timer=0.
- All outputs are registered. rx_valid at edge n → key_up/key_down and any state change visible after edge n+1.
- pts at edge n → score, balls_left and state all updated together at edge n+1.
- Timer: loaded on state entry and decremented on each frame_tick. timer_up = (timer==0). Exactly SERVE_FRAMES frame_ticks are needed before a start key is accepted.
- frame_tick and rx_valid in the same cycle: the reload wins over the decrement.
- An asynchronous reset mid-game returns everything to reset values immediately.

## Configuration
- PONG_WIN_SCORE_EN defined: a score reaching WIN_SCORE (binary compare of the BCD value) forces OVER immediately, even if balls remain. winner = that player.
- PONG_WIN_SCORE_EN undefined: the game ends only when balls run out. WIN_SCORE has no effect.

## Structure
- pong_pkg: state encodings, key-code constants (up/down arrays, space), and a BCD-to-binary helper function.
- One sub-module, pong_bcd_counter (DIGITS-parameterised, inc/clr inputs, wrap), instantiated once per player in a generate loop.

## Test plan
- Reset, then send 8'h20 → state 01 after one clk, balls_left=7, scores=0, gra_still=0.
- In play, pulse pts=2'b01 → player-0 score 01, balls_left=6, state 10. Send 'w' before 120 frame_ticks → stays in 10. Send 'w' after 120 → state 01.
- Pulse pts=2'b11 → only player 0 increments, balls_left decrements by 1.
- Send 's' then run 4 frame_ticks → key_down[0]=1 for exactly 4 frames. Send 'w' mid-hold → key_down[0]=0 and key_up[0]=1 the next cycle.
- Use all 7 balls → state 11, winner = higher scorer. After 180 frame_ticks → state 00, scores cleared.
- With PONG_WIN_SCORE_EN and WIN_SCORE=3: player 1 scores 3 → state 11 with winner=1 while balls_left>0. Assert reset mid-over → all outputs return to reset values.
